// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster geometry and the 12-bit colour type
// shared by the timing generator and the draw units.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: enable-gated shift register that lines up raster control bits
// with the draw-mux latency; reset loads every stage with the blank pattern.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] BLANK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH*DEPTH-1:0]     sr_q;
    logic [WIDTH*DEPTH-1:0]     sr_d;
    logic [WIDTH*(DEPTH+1)-1:0] shifted;

    // Shift one slot toward the output on each enable; the oldest entry drops off.
    always_comb begin
        shifted = {sr_q, din};
        sr_d    = en ? shifted[WIDTH*DEPTH-1:0] : sr_q;
    end

    // Shift register state; reset flushes the line to blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= {DEPTH{BLANK}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[WIDTH*DEPTH-1 -: WIDTH];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, raster counters, frame strobe and the
// final blanked, sync-aligned VGA output register stage.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic [31:0] pxl_x,
    output logic [31:0] pxl_y,
    output logic        pxl_tick,
    output logic        active,
    output logic        frame,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);
    import vga_timing_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_PRE_BLNK = VW'(V_ACTIVE - 1);

    localparam logic [31:0] H_ACT_W  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_W  = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_q, frame_d;
    rgb12_t        vga_rgb_q, vga_rgb_d;
    logic          vga_hs_q, vga_hs_d;
    logic          vga_vs_q, vga_vs_d;

    logic          hs_raw, vs_raw;
    logic [2:0]    dly_out;
    logic          active_dly, hs_dly, vs_dly;

    // Raster coordinates and the per-coordinate control bits derived from them.
    assign pxl_x    = 32'(h_q);
    assign pxl_y    = 32'(v_q);
    assign pxl_tick = ~reset & (div_cnt_q == DIV_LAST);
    assign active   = (pxl_x < H_ACT_W) && (pxl_y < V_ACT_W);
    assign hs_raw   = (pxl_x >= HS_START) && (pxl_x < HS_END);
    assign vs_raw   = (pxl_y >= VS_START) && (pxl_y < VS_END);

    // Control bits travel alongside the draw-mux pipeline so they meet their own colour.
    vga_sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY),
        .BLANK (3'b000)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pxl_tick),
        .din   ({active, hs_raw, vs_raw}),
        .dout  (dly_out)
    );

    assign {active_dly, hs_dly, vs_dly} = dly_out;

    // Next-state: clock divider, scan counters and the start-of-vblank strobe.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        h_d       = h_q;
        v_d       = v_q;
        frame_d   = 1'b0;
        if (pxl_tick) begin
            if (h_q == H_LAST) begin
                h_d     = '0;
                v_d     = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                frame_d = (v_q == V_PRE_BLNK);
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Next-state: output stage samples the mux colour on each tick; blanking masks
    // the colour outright so an undriven rgb_in never reaches the DAC.
    always_comb begin
        vga_rgb_d = vga_rgb_q;
        vga_hs_d  = vga_hs_q;
        vga_vs_d  = vga_vs_q;
        if (pxl_tick) begin
            vga_rgb_d = active_dly ? rgb12_t'(rgb_in) : '0;
            vga_hs_d  = hs_dly ? SYNC_ACT : SYNC_IDLE;
            vga_vs_d  = vs_dly ? SYNC_ACT : SYNC_IDLE;
        end
    end

    // State registers; reset returns to the top-left corner with blank, idle outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            h_q       <= '0;
            v_q       <= '0;
            frame_q   <= 1'b0;
            vga_rgb_q <= '0;
            vga_hs_q  <= SYNC_IDLE;
            vga_vs_q  <= SYNC_IDLE;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_q       <= h_d;
            v_q       <= v_d;
            frame_q   <= frame_d;
            vga_rgb_q <= vga_rgb_d;
            vga_hs_q  <= vga_hs_d;
            vga_vs_q  <= vga_vs_d;
        end
    end

    assign frame  = frame_q;
    assign vga_r  = vga_rgb_q.r;
    assign vga_g  = vga_rgb_q.g;
    assign vga_b  = vga_rgb_q.b;
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

endmodule
